// File: rtl/layer_sched_pkg.sv
// Shared types for the layer scheduler: FSM states, command header layout
// and accelerator mode encodings.
package layer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_MM     = 2'd0,
    MODE_MM_ACC = 2'd1,
    MODE_ELT    = 2'd2,
    MODE_RAW    = 2'd3
  } acc_mode_t;

  // Command word is {tag, hdr}; hdr holds relu above mode.
  typedef struct packed {
    logic       relu;
    logic [1:0] mode;
  } cmd_hdr_t;

  localparam int CMD_HDR_W = $bits(cmd_hdr_t);

endpackage

// File: rtl/sched_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// DEPTH must be a power of two, at least 2.
module sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_n;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_comb begin
    cnt_n = cnt;
    if (do_push) cnt_n = cnt_n + 1'b1;
    if (do_pop)  cnt_n = cnt_n - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt   <= cnt_n;
      full  <= (cnt_n == DEPTH[AW:0]);
      empty <= (cnt_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/layer_sched.sv
// Layer job scheduler: queues commands, launches one job at a time, reports.
// Optional perf counters enabled with LAYER_SCHED_PERF_EN.
module layer_sched
  import layer_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TO_W  = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic             i_cmd_relu,
  input  logic [TAG_W-1:0] i_cmd_tag,
  input  logic [TO_W-1:0]  i_timeout_lim,
  output logic [1:0]       o_acc_mode,
  output logic             o_acc_relu_en,
  output logic             o_acc_start,
  input  logic             i_acc_tile_done,
  input  logic             i_acc_finish,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [15:0]      o_rsp_tiles,
  output logic             o_rsp_timeout,
  output logic             o_busy,
  output logic [31:0]      o_perf_busy_cyc,
  output logic [15:0]      o_perf_jobs
);

  localparam int CMD_W = TAG_W + CMD_HDR_W;

  state_t           state_q;
  state_t           state_n;
  logic             rdy_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             expire;
  logic             wd_hit;
  logic [CMD_W-1:0] wcmd;
  logic [CMD_W-1:0] head;
  cmd_hdr_t         hdr;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       mode_q;
  logic             relu_q;
  logic [15:0]      tiles_q;
  logic             to_q;
  logic [TO_W-1:0]  wd_q;
  logic [TO_W-1:0]  lim_m1;

  assign hdr  = '{relu: i_cmd_relu, mode: i_cmd_mode};
  assign wcmd = {i_cmd_tag, hdr};

  // Ready is built only from flops so a pop never reaches it combinationally.
  assign o_cmd_ready = rdy_q && !full;
  assign push        = i_cmd_valid && o_cmd_ready;

  sched_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign lim_m1 = i_timeout_lim - TO_W'(1);
  assign wd_hit = (i_timeout_lim != '0) && (wd_q == lim_m1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_n = state_q;
    pop     = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: state_n = RUN;
      RUN: begin
        if (i_acc_finish) begin
          state_n = REPORT;
        end else if (wd_hit) begin
          state_n = REPORT;
          expire  = 1'b1;
        end
      end
      REPORT: begin
        // A queued job launches straight out of the handshake cycle.
        if (i_rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = LAUNCH;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q   <= '0;
      mode_q  <= '0;
      relu_q  <= 1'b0;
      tiles_q <= '0;
      to_q    <= 1'b0;
      wd_q    <= '0;
    end else if (pop) begin
      tag_q   <= head[CMD_W-1:CMD_HDR_W];
      mode_q  <= head[1:0];
      relu_q  <= head[2];
      tiles_q <= '0;
      to_q    <= 1'b0;
      wd_q    <= '0;
    end else if (state_q == RUN) begin
      wd_q <= wd_q + 1'b1;
      to_q <= expire;
      if (i_acc_tile_done && tiles_q != 16'hFFFF)
        tiles_q <= tiles_q + 1'b1;
    end
  end

  assign o_acc_mode    = mode_q;
  assign o_acc_relu_en = relu_q;
  assign o_acc_start   = (state_q == LAUNCH);
  assign o_rsp_valid   = (state_q == REPORT);
  assign o_rsp_tag     = tag_q;
  assign o_rsp_tiles   = tiles_q;
  assign o_rsp_timeout = to_q;
  assign o_busy        = (state_q != IDLE) || !empty;

`ifdef LAYER_SCHED_PERF_EN
  logic [31:0] busy_cyc_q;
  logic [15:0] jobs_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_cyc_q <= '0;
      jobs_q     <= '0;
    end else begin
      if (state_q == RUN)
        busy_cyc_q <= busy_cyc_q + 1'b1;
      if (state_q == REPORT && i_rsp_ready && jobs_q != 16'hFFFF)
        jobs_q <= jobs_q + 1'b1;
    end
  end

  assign o_perf_busy_cyc = busy_cyc_q;
  assign o_perf_jobs     = jobs_q;
`else
  assign o_perf_busy_cyc = '0;
  assign o_perf_jobs     = '0;
`endif

endmodule

// File: tb/tb_layer_sched.sv
// Scoreboard bench for layer_sched: a script-driven accelerator model,
// a job-level reference model and a response monitor.
module tb_layer_sched;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TO_W  = 20;

  typedef struct {
    int fin;
    int nt;
    bit tend;
  } plan_t;

  typedef struct {
    logic [3:0] tag;
    int         tiles;
    bit         to;
    int         lat;
    int         runc;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic       relu;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_relu;
  logic [TAG_W-1:0] cmd_tag;
  logic [TO_W-1:0]  lim;
  logic [1:0]       acc_mode;
  logic             acc_relu;
  logic             acc_start;
  logic             acc_tile;
  logic             acc_fin;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      rsp_tiles;
  logic             rsp_to;
  logic             busy;
  logic [31:0]      perf_busy;
  logic [15:0]      perf_jobs;

  layer_sched #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .TO_W  (TO_W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_mode      (cmd_mode),
    .i_cmd_relu      (cmd_relu),
    .i_cmd_tag       (cmd_tag),
    .i_timeout_lim   (lim),
    .o_acc_mode      (acc_mode),
    .o_acc_relu_en   (acc_relu),
    .o_acc_start     (acc_start),
    .i_acc_tile_done (acc_tile),
    .i_acc_finish    (acc_fin),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_tag       (rsp_tag),
    .o_rsp_tiles     (rsp_tiles),
    .o_rsp_timeout   (rsp_to),
    .o_busy          (busy),
    .o_perf_busy_cyc (perf_busy),
    .o_perf_jobs     (perf_jobs)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_push = 0;
  int    n_start = 0;
  int    last_start = 0;
  longint jc = 0;
  longint rc = 0;
  bit    hold = 1'b0;
  bit    rnd = 1'b0;

  cmd_t  cq[$];
  plan_t pq[$];
  exp_t  eq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Job-level outcome: the job ends at the finish cycle unless the
  // watchdog limit runs out first; tiles up to and including that cycle count.
  function automatic exp_t model(input plan_t p, input int l,
                                 input logic [3:0] tag);
    exp_t r;
    int   e;
    r.tag = tag;
    if (p.fin >= 0 && (l == 0 || p.fin <= l - 1)) begin
      e    = p.fin;
      r.to = 1'b0;
    end else begin
      e    = l - 1;
      r.to = 1'b1;
    end
    r.tiles = 0;
    for (int k = 0; k <= e; k++)
      if (k < p.nt || (p.tend && k == p.fin)) r.tiles++;
    r.lat  = e + 2;
    r.runc = e + 1;
    return r;
  endfunction

  task automatic play(input plan_t p);
    int last;
    last = (p.fin > p.nt - 1) ? p.fin : p.nt - 1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      acc_tile = (k < p.nt) || (p.tend && k == p.fin);
      acc_fin  = (k == p.fin);
    end
    @(posedge clk);
    #1;
    acc_tile = 1'b0;
    acc_fin  = 1'b0;
  endtask

  // Accelerator model: plays the job's script from the RUN cycle after start.
  initial begin
    acc_tile = 1'b0;
    acc_fin  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && acc_start && pq.size() > 0) play(pq.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Start pulse checks and accelerator config stability.
  cmd_t cur;
  bit   cur_v = 1'b0;
  bit   prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_v      = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (acc_start) begin
        n_start++;
        chk("start_width", prev_start, 0);
        if (cq.size() == 0) begin
          chk("start_unexpected", acc_start, 0);
        end else begin
          cur = cq.pop_front();
          chk("launch_mode", acc_mode, cur.mode);
          chk("launch_relu", acc_relu, cur.relu);
          cur_v      = 1'b1;
          last_start = cyc;
        end
      end else if (cur_v) begin
        chk("mode_stable", acc_mode, cur.mode);
        chk("relu_stable", acc_relu, cur.relu);
      end
      prev_start = acc_start;
    end
  end

  // Response monitor / scoreboard.
  bit          pv = 1'b0;
  int          rise = 0;
  logic [3:0]  s_tag;
  logic [15:0] s_tiles;
  logic        s_to;
  exp_t        ex;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (rsp_valid && !pv) begin
        rise    = cyc;
        s_tag   = rsp_tag;
        s_tiles = rsp_tiles;
        s_to    = rsp_to;
      end else if (rsp_valid) begin
        chk("rsp_stable_tag", rsp_tag, s_tag);
        chk("rsp_stable_tiles", rsp_tiles, s_tiles);
        chk("rsp_stable_to", rsp_to, s_to);
      end
      if (rsp_valid && rsp_ready) begin
        if (eq.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          ex = eq.pop_front();
          chk("rsp_tag", rsp_tag, ex.tag);
          chk("rsp_tiles", rsp_tiles, ex.tiles);
          chk("rsp_timeout", rsp_to, ex.to);
          chk("rsp_latency", rise - last_start, ex.lat);
          jc++;
          rc += ex.runc;
        end
      end
      pv = rsp_valid;
    end
  end

  task automatic push_cmd(input logic [1:0] m, input logic r,
                          input logic [3:0] t, input plan_t p);
    int   w;
    cmd_t c;
    w = 0;
    while (!cmd_ready && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", cmd_ready, 1);
    end else begin
      cmd_valid = 1'b1;
      cmd_mode  = m;
      cmd_relu  = r;
      cmd_tag   = t;
      c.mode    = m;
      c.relu    = r;
      cq.push_back(c);
      pq.push_back(p);
      eq.push_back(model(p, int'(lim), t));
      n_push++;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while ((eq.size() != 0 || busy) && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk(nm, eq.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_perf(input string nm);
`ifdef LAYER_SCHED_PERF_EN
    chk({nm, "_jobs"}, perf_jobs, jc);
    chk({nm, "_busy"}, perf_busy, rc);
`else
    chk({nm, "_jobs"}, perf_jobs, 0);
    chk({nm, "_busy"}, perf_busy, 0);
`endif
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, cmd_ready, 0);
    chk({nm, "_start"}, acc_start, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_mode"}, acc_mode, 0);
    chk({nm, "_relu"}, acc_relu, 0);
    chk({nm, "_tag"}, rsp_tag, 0);
    chk({nm, "_tiles"}, rsp_tiles, 0);
    chk({nm, "_to"}, rsp_to, 0);
    chk({nm, "_pbusy"}, perf_busy, 0);
    chk({nm, "_pjobs"}, perf_jobs, 0);
  endtask

  task automatic rand_job();
    plan_t p;
    if (lim == '0 || $urandom_range(0, 1) == 1) begin
      p.fin = (lim == '0) ? int'($urandom_range(3, 20))
                          : int'($urandom_range(2, int'(lim) - 1));
      p.nt  = $urandom_range(0, p.fin);
    end else begin
      p.fin = -1;
      p.nt  = $urandom_range(0, int'(lim) - 2);
    end
    p.tend = 1'($urandom_range(0, 1));
    push_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), p);
    idle($urandom_range(0, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound expired at cycle %0d", cyc);
    $fatal(1, "tb_layer_sched hung");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = '0;
    cmd_relu  = 1'b0;
    cmd_tag   = '0;
    lim       = '0;
    @(negedge clk);
    chk_zero("reset");
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_clk", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_clk", cmd_ready, 1);

    // Single job, also the first of the two perf jobs (20 RUN cycles).
    push_cmd(2'd1, 1'b1, 4'd5, '{fin: 19, nt: 3, tend: 1'b0});
    drain("drain_single");
    chk("single_starts", n_start, 1);
    push_cmd(2'd0, 1'b0, 4'd6, '{fin: 29, nt: 4, tend: 1'b1});
    drain("drain_perf");
    idle(2);
`ifdef LAYER_SCHED_PERF_EN
    chk("perf_jobs_two", perf_jobs, 2);
    chk("perf_busy_fifty", perf_busy, 50);
`endif
    chk_perf("perf_a");

    // Back-to-back: a running job keeps the FIFO from draining.
    push_cmd(2'd2, 1'b0, 4'd0, '{fin: 12, nt: 0, tend: 1'b0});
    for (int j = 1; j <= 4; j++)
      push_cmd(2'(j), 1'(j), 4'(j),
               '{fin: 3 + j, nt: j, tend: 1'(j % 2)});
    chk("ready_full", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_tag   = 4'd9;
    cmd_mode  = 2'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain("drain_b2b");
    chk("b2b_starts", n_start, n_push);

    // Watchdog expiry; the late finish lands in IDLE.
    lim = 20'd10;
    push_cmd(2'd3, 1'b1, 4'd11, '{fin: 15, nt: 2, tend: 1'b0});
    drain("drain_wd");
    idle(12);
    chk("wd_idle_busy", busy, 0);
    chk("wd_idle_valid", rsp_valid, 0);

    // Finish, watchdog and tile_done on the same cycle.
    lim = 20'd8;
    push_cmd(2'd1, 1'b0, 4'd12, '{fin: 7, nt: 2, tend: 1'b1});
    drain("drain_coinc");

    // Randomized batches with random response backpressure.
    rnd = 1'b1;
    lim = '0;
    for (int j = 0; j < 8; j++) rand_job();
    drain("drain_rand0");
    lim = 20'd12;
    for (int j = 0; j < 8; j++) rand_job();
    drain("drain_rand1");
    rnd = 1'b0;
    lim = '0;
    idle(2);
    chk_perf("perf_b");

    // Long backpressure.
    hold = 1'b1;
    push_cmd(2'd2, 1'b0, 4'd7, '{fin: 5, nt: 2, tend: 1'b0});
    begin
      int w;
      w = 0;
      while (!rsp_valid && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
    end
    chk("bp_valid_seen", rsp_valid, 1);
    for (int j = 0; j < 50; j++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", rsp_valid, 1);
    end
    hold = 1'b0;
    drain("drain_bp");

    // Reset during RUN abandons the job.
    push_cmd(2'd1, 1'b1, 4'd13, '{fin: -1, nt: 3, tend: 1'b0});
    idle(10);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    eq.delete();
    cq.delete();
    pq.delete();
    jc = 0;
    rc = 0;
    @(negedge clk);
    chk_zero("midrst");
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_before_clk", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_ready_after_clk", cmd_ready, 1);
    idle(30);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_tiles", rsp_tiles, 0);
    push_cmd(2'd3, 1'b0, 4'd14, '{fin: 6, nt: 5, tend: 1'b1});
    drain("drain_recover");
    idle(2);
    chk_perf("perf_c");
    chk("starts_total", n_start, n_push);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
- Job scheduler in front of the matrix-multiply + post-processing accelerator.
- Accepts a queue of layer commands (mode, relu enable, tag) and launches them one at a time with a single-cycle start pulse.
- Holds the configuration stable while the job runs and waits for the accelerator's finish.
- Returns one response per job carrying tile count and timeout status, so the host never drives the accelerator control lines directly.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TAG_W, 4, width of the host job tag
TO_W, 20, width of the per-job watchdog counter and limit

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command offered
o_cmd_ready  output  1  FIFO can accept a command
i_cmd_mode  input  2  accelerator mode for the job
i_cmd_relu  input  1  relu enable for the job
i_cmd_tag  input  TAG_W  host tag, echoed in the response
i_timeout_lim  input  TO_W  watchdog limit in cycles; 0 disables the watchdog
o_acc_mode  output  2  mode driven to the accelerator
o_acc_relu_en  output  1  relu enable driven to the accelerator
o_acc_start  output  1  one-cycle start pulse
i_acc_tile_done  input  1  tile-done pulse from the accelerator
i_acc_finish  input  1  finish pulse from the accelerator
o_rsp_valid  output  1  response available
i_rsp_ready  input  1  host consumes the response
o_rsp_tag  output  TAG_W  tag of the completed job
o_rsp_tiles  output  16  tile_done pulses counted during the job
o_rsp_timeout  output  1  job ended by the watchdog
o_busy  output  1  scheduler not idle or FIFO not empty
o_perf_busy_cyc  output  32  cycles spent in RUN (optional feature)
o_perf_jobs  output  16  completed jobs (optional feature)

Behaviour:
- Reset: all outputs are 0, FIFO is empty, FSM is in IDLE.
  - o_cmd_ready rises on the first clock after reset release.
  - Reset asserted mid-job abandons the job and drops the queue; no response is produced.
- Command handshake:
  - Push when i_cmd_valid && o_cmd_ready.
  - o_cmd_ready = !full, registered. There is no combinational path from a same-cycle pop.
  - A push while full is ignored.
- FSM states: IDLE, LAUNCH, RUN, REPORT.
  - IDLE: if the FIFO is non-empty, pop the head, latch mode/relu/tag into output registers, clear the tile and watchdog counters, go to LAUNCH. A command pushed in cycle N can start LAUNCH no earlier than N+2.
  - LAUNCH: o_acc_start=1 for exactly this cycle, then go to RUN.
  - RUN:
    - Each i_acc_tile_done increments the tile counter, which saturates at 0xFFFF.
    - The watchdog increments each cycle.
    - On i_acc_finish go to REPORT with timeout=0.
    - Else, if i_timeout_lim!=0 and the watchdog equals i_timeout_lim-1, go to REPORT with timeout=1.
    - If finish and watchdog expiry coincide, finish wins.
    - If tile_done coincides with finish, that tile is counted.
  - REPORT: o_rsp_valid=1, with tag, tiles and timeout held stable until i_rsp_ready. On handshake go to IDLE. A back-to-back job starts LAUNCH one cycle after the handshake cycle.
- o_acc_mode and o_acc_relu_en stay constant from LAUNCH until the next LAUNCH, including through REPORT and IDLE.
- i_acc_finish and i_acc_tile_done are ignored outside RUN, including a finish arriving in the LAUNCH cycle.
- i_timeout_lim is sampled every cycle. Changing it mid-job is legal and takes effect immediately.
- o_busy = (state!=IDLE) || !empty.
- Mode value 2'b11 is passed through unchecked.

Optional Feature:
- Macro: LAYER_SCHED_PERF_EN.
- Defined:
  - o_perf_busy_cyc increments every RUN cycle, wrapping at 2^32.
  - o_perf_jobs increments on each response handshake, saturating at 0xFFFF.
  - Both are cleared only by reset.
- Undefined: both ports exist and are tied to 0, and no counter flops are generated.

Decomposition:
- Shared package/defines header holds:
  - the state encoding localparams (IDLE=0, LAUNCH=1, RUN=2, REPORT=3);
  - the command word layout {tag, relu, mode} and its width CMD_W=TAG_W+3;
  - the accelerator mode encodings.
- One sub-module, sched_fifo: synchronous FIFO parameterised by width and depth, with push/pop/full/empty, registered full/empty, and async active-low reset.

Test Plan:
- Single job: push {mode=1, relu=1, tag=5}, then 3 tile_done pulses and finish 20 cycles after start.
  - Required: exactly one start pulse; mode=1 and relu=1 stable.
  - Response tag=5, tiles=3, timeout=0.
- Back-to-back: push 4 jobs with no gaps, tags 1-4.
  - Required: o_cmd_ready low after the 4th push; 5th push ignored.
  - Responses in order 1,2,3,4, with exactly one start per job.
- Watchdog: i_timeout_lim=10, no finish.
  - Required: response 10 cycles after entering RUN, with timeout=1.
  - A later finish pulse in IDLE is ignored.
- Finish and timeout on the same cycle, with tile_done in that same cycle.
  - Required: timeout=0 and the tile is counted.
- Response backpressure and reset: hold i_rsp_ready=0 for 50 cycles, then pulse it; assert i_rst_n low during a later RUN.
  - Required: response held stable for the full 50 cycles.
  - After reset: outputs 0, queue empty, no stale response.
- With LAYER_SCHED_PERF_EN: run 2 jobs of 20 and 30 RUN cycles.
  - Required: o_perf_jobs=2, o_perf_busy_cyc=50.
